// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector controller: state encoding
// and the serial line level used whenever no word bit is being sent.
package seq_det_pkg;

  // One-hot controller states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SHIFT  = 4'b0010,
    ST_DRAIN  = 4'b0100,
    ST_REPORT = 4'b1000
  } state_t;

  // Level driven on det_din outside of a scan (and shifted into the PISO tail)
  localparam logic DET_IDLE_BIT = 1'b1;

endpackage

// File: rtl/seq_det_piso.sv
// Parallel-in/serial-out register feeding the detector.
// The first stream bit is taken straight from the load data so the parent
// can register it at the accept edge; the register is loaded pre-shifted,
// so its head always holds the bit that goes out on the following cycle.
// idx counts the bit currently on the line and parks at W-1 on the last bit.
module seq_det_piso
  import seq_det_pkg::*;
#(
  parameter int  W         = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int IW        = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  din,
  output logic          first_bit,
  output logic          next_bit,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [W-1:0]  sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  load_val;
  logic [W-1:0]  shift_val;

  // Bit order selection: MSB-first shifts left, LSB-first shifts right
  if (MSB_FIRST) begin : g_msb
    assign first_bit = din[W-1];
    assign next_bit  = sr_q[W-1];
    assign load_val  = {din[W-2:0], DET_IDLE_BIT};
    assign shift_val = {sr_q[W-2:0], DET_IDLE_BIT};
  end else begin : g_lsb
    assign first_bit = din[0];
    assign next_bit  = sr_q[0];
    assign load_val  = {DET_IDLE_BIT, din[W-1:1]};
    assign shift_val = {DET_IDLE_BIT, sr_q[W-1:1]};
  end

  assign idx  = idx_q;
  assign last = (idx_q == IW'(W - 1));

  // Next-state for shift register and bit index
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = load_val;
      idx_d = '0;
    end else if (shift) begin
      sr_d  = shift_val;
      idx_d = idx_q + IW'(1);
    end
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= {W{DET_IDLE_BIT}};
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequencing controller for the serial 0101_0101 pattern detector.
// Accepts a word, streams it into the detector one bit per cycle, counts the
// detector's flags (which lag their bit by one cycle) and reports the hit
// count and first-hit index. The detector is held in reset outside a scan so
// each word starts from a clean detector state. det_rst/det_din are flops so
// the detector's async reset never sees combinational glitches.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int  W         = 16,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int CW        = $clog2(W + 1),
  localparam int IW        = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_hits,
  output logic [IW-1:0] out_first,
  output logic          out_any,
  output logic          busy,
  output logic          det_rst,
  output logic          det_din,
  input  logic          det_flag
);

  state_t        state_q, state_d;
  logic          det_rst_q, det_rst_d;
  logic          det_din_q, det_din_d;
  logic [CW-1:0] hits_q, hits_d;
  logic [IW-1:0] first_q, first_d;
  logic          any_q, any_d;

  logic          piso_load, piso_shift;
  logic          first_bit, next_bit, last_bit;
  logic [IW-1:0] bit_idx;

  logic          accept;
  logic          scanning;
  logic          abort_scan;
  logic          samp_vld;
  logic [IW-1:0] samp_idx;

  seq_det_piso #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (piso_load),
    .shift     (piso_shift),
    .din       (in_data),
    .first_bit (first_bit),
    .next_bit  (next_bit),
    .idx       (bit_idx),
    .last      (last_bit)
  );

  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign scanning   = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign abort_scan = scanning && abort;

  // Next state, detector controls and PISO strobes
  always_comb begin
    state_d    = state_q;
    det_rst_d  = det_rst_q;
    det_din_d  = DET_IDLE_BIT;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        det_rst_d = 1'b1;
        if (in_valid) begin
          // Release the detector and put bit 0 on the line at the same edge
          piso_load = 1'b1;
          det_rst_d = 1'b0;
          det_din_d = first_bit;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_rst_d = 1'b0;
        if (abort) begin
          det_rst_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (last_bit) begin
          state_d = ST_DRAIN;
        end else begin
          piso_shift = 1'b1;
          det_din_d  = next_bit;
        end
      end
      ST_DRAIN: begin
        // The last flag arrives this cycle; the detector is reset afterwards
        det_rst_d = 1'b1;
        state_d   = abort ? ST_IDLE : ST_REPORT;
      end
      ST_REPORT: begin
        det_rst_d = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        det_rst_d = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Flag sample qualification: in SHIFT the flag belongs to the previous
  // bit (nothing to sample on bit 0); in DRAIN it belongs to bit W-1, where
  // the PISO index has parked.
  always_comb begin
    samp_vld = ((state_q == ST_SHIFT) && (bit_idx != '0)) ||
               (state_q == ST_DRAIN);
    samp_idx = (state_q == ST_DRAIN) ? bit_idx : (bit_idx - IW'(1));
  end

  // Hit counter and first-hit latch
  always_comb begin
    hits_d  = hits_q;
    first_d = first_q;
    any_d   = any_q;
    if (accept || abort_scan) begin
      hits_d  = '0;
      first_d = '0;
      any_d   = 1'b0;
    end else if (samp_vld && det_flag) begin
      hits_d = hits_q + CW'(1);
      if (!any_q) begin
        first_d = samp_idx;
        any_d   = 1'b1;
      end
    end
  end

  // State, detector drive and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      det_rst_q <= 1'b1;
      det_din_q <= DET_IDLE_BIT;
      hits_q    <= '0;
      first_q   <= '0;
      any_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      det_rst_q <= det_rst_d;
      det_din_q <= det_din_d;
      hits_q    <= hits_d;
      first_q   <= first_d;
      any_q     <= any_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_REPORT);
  assign busy      = scanning;
  assign out_hits  = hits_q;
  assign out_first = first_q;
  assign out_any   = any_q;
  assign det_rst   = det_rst_q;
  assign det_din   = det_din_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a behavioural 0101_0101 detector is attached to the
// serial port, and each word's result is compared with a pattern scan of the
// word computed directly from its bit stream.
module tb_seq_det_ctrl;

  localparam int W   = 16;
  localparam bit MSB = 1'b1;
  localparam int CW  = $clog2(W + 1);
  localparam int IW  = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_hits;
  logic [IW-1:0] out_first;
  logic          out_any;
  logic          busy;
  logic          det_rst;
  logic          det_din;
  logic          det_flag;

  int total = 0;
  int bad   = 0;

  seq_det_ctrl #(.W(W), .MSB_FIRST(MSB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hits  (out_hits),
    .out_first (out_first),
    .out_any   (out_any),
    .busy      (busy),
    .det_rst   (det_rst),
    .det_din   (det_din),
    .det_flag  (det_flag)
  );

  always #5 clk = ~clk;

  // Detector: registered Mealy flag for 0101_0101 with overlap, async reset
  logic [7:0] dh;
  int         dcnt;
  always @(posedge clk or posedge det_rst) begin
    if (det_rst) begin
      dh       <= '0;
      dcnt     <= 0;
      det_flag <= 1'b0;
    end else begin
      dh       <= {dh[6:0], det_din};
      dcnt     <= (dcnt < 8) ? dcnt + 1 : 8;
      det_flag <= (dcnt >= 7) && ({dh[6:0], det_din} == 8'h55);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected result: scan the transmitted bit stream for every window
  // equal to 0,1,0,1,0,1,0,1 in send order
  function automatic void ref_scan(input logic [W-1:0] d, output int hits,
                                   output int first, output int any);
    bit b[W];
    bit m;
    for (int i = 0; i < W; i++) b[i] = MSB ? d[W-1-i] : d[i];
    hits = 0; first = 0; any = 0;
    for (int i = 7; i < W; i++) begin
      m = 1'b1;
      for (int j = 0; j < 8; j++) if (b[i-7+j] != bit'(j % 2)) m = 1'b0;
      if (m) begin
        hits++;
        if (any == 0) begin first = i; any = 1; end
      end
    end
  endfunction

  // Send one word, check scan behaviour, latency and result, then hold the
  // result for 'hold' cycles before consuming it.
  task automatic run_word(input logic [W-1:0] d, input int hold,
                          input bit ab_acc, input bit ab_rep);
    int eh, ef, ea, n, scan_bad;
    ref_scan(d, eh, ef, ea);
    @(negedge clk);
    chk("idle_rdy", in_ready, 1);
    chk("idle_detrst", det_rst, 1);
    in_valid  = 1'b1;
    in_data   = d;
    abort     = ab_acc;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    in_data  = W'($urandom);
    chk("acc_busy", busy, 1);
    n = 0;
    scan_bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready || det_rst || !busy) scan_bad++;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, W + 1);
    chk("scan_ctl", scan_bad, 0);
    chk("hits", out_hits, eh);
    chk("first", out_first, ef);
    chk("any", out_any, ea);
    chk("rep_rdy", in_ready, 0);
    chk("rep_detrst", det_rst, 1);
    for (int i = 0; i < hold; i++) begin
      abort = ab_rep && (i == 0);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk("hold_vld", out_valid, 1);
      chk("hold_hits", out_hits, eh);
      chk("hold_first", out_first, ef);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_vld", out_valid, 0);
    chk("done_rdy", in_ready, 1);
    chk("post_hits", out_hits, eh);
  endtask

  initial begin
    int cnt;
    logic [W-1:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_hits", out_hits, 0);
    chk("rst_first", out_first, 0);
    chk("rst_any", out_any, 0);
    chk("rst_busy", busy, 0);
    chk("rst_detrst", det_rst, 1);
    chk("rst_detdin", det_din, 1);
    rst_n = 1'b1;

    // Directed words with known answers
    run_word(16'h5555, 2, 1'b0, 1'b0);
    run_word(16'hFFFF, 1, 1'b0, 1'b0);
    run_word(16'h0055, 1, 1'b0, 1'b0);
    // Back-to-back with out_ready already high
    run_word(16'h5555, 0, 1'b0, 1'b0);
    run_word(16'h0055, 0, 1'b0, 1'b0);
    // Long REPORT hold with an abort pulse that must not discard the result
    run_word(16'h5555, 10, 1'b0, 1'b1);
    // Abort together with in_valid in IDLE: word still accepted
    run_word(16'h0055, 1, 1'b1, 1'b0);

    // Abort at SHIFT bit 8
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_rdy", in_ready, 1);
    chk("ab_detrst", det_rst, 1);
    chk("ab_busy", busy, 0);
    chk("ab_hits", out_hits, 0);
    chk("ab_any", out_any, 0);
    cnt = 0;
    repeat (25) begin @(negedge clk); if (out_valid) cnt++; end
    chk("ab_novld", cnt, 0);
    run_word(16'h0055, 1, 1'b0, 1'b0);

    // Async reset mid-scan after a hit has been counted
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("mid_hits", out_hits, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", in_ready, 1);
    chk("arst_vld", out_valid, 0);
    chk("arst_hits", out_hits, 0);
    chk("arst_first", out_first, 0);
    chk("arst_any", out_any, 0);
    chk("arst_busy", busy, 0);
    chk("arst_detrst", det_rst, 1);
    chk("arst_detdin", det_din, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized words, biased toward the pattern so hits occur
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       d = W'($urandom);
        1:       d = 16'h5555 ^ W'(1 << $urandom_range(0, W - 1));
        default: d = (16'h5555 << $urandom_range(0, 8)) | W'($urandom_range(0, 3));
      endcase
      run_word(d, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
